// File: rtl/pdpu_align_serializer.sv
// pdpu_align_serializer: registers one PDPU vector and streams its lanes one per beat, each mantissa aligned to exp_max with a sticky bit
module pdpu_align_serializer #(
   parameter int N       = 4,
   parameter int WIDTH   = 8,
   parameter int MANT_W  = 8,
   parameter int ALIGN_W = 16,
   localparam int IW     = (N > 1) ? $clog2(N) : 1
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic signed [WIDTH:0]      exp_max_i,
   input  logic [N*(WIDTH+1)-1:0]     exp_i,
   input  logic [N*MANT_W-1:0]        mant_i,
   input  logic [N-1:0]               sign_i,
   input  logic [N-1:0]               zero_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [ALIGN_W-1:0]         out_mant_o,
   output logic                       out_sticky_o,
   output logic                       out_sign_o,
   output logic [IW-1:0]              out_idx_o,
   output logic                       out_last_o,
   output logic                       err_o
);
   localparam int EW = WIDTH + 1;
   typedef enum logic {IDLE, SEND} state_t;
   state_t              state_q;
   logic [IW-1:0]       idx_q;
   logic [N*EW-1:0]     exp_q;
   logic [N*MANT_W-1:0] mant_q;
   logic [N-1:0]        sign_q, zero_q;
   logic [EW-1:0]       exp_max_q;
   logic                err_q;
   logic                last, xfer, accept, neg, big, zero_sel;
   logic [EW-1:0]       exp_sel;
   logic [MANT_W-1:0]   mant_sel;
   logic signed [WIDTH+1:0] d;
   logic [ALIGN_W-1:0]  ext, mask;

   // handshake and per-lane alignment of the lane selected by the index
   always_comb begin
      last         = idx_q == IW'(N - 1);
      out_valid_o  = state_q == SEND;
      xfer         = out_valid_o && out_ready_i;
      in_ready_o   = !out_valid_o || (out_ready_i && last);
      accept       = in_valid_i && in_ready_o;
      exp_sel      = exp_q[idx_q*EW +: EW];
      mant_sel     = mant_q[idx_q*MANT_W +: MANT_W];
      zero_sel     = zero_q[idx_q];
      d            = {exp_max_q[WIDTH], exp_max_q} - {exp_sel[WIDTH], exp_sel};
      neg          = d < 0;
      big          = d >= ALIGN_W;
      ext          = ALIGN_W'(mant_sel) << (ALIGN_W - MANT_W);
      mask         = ~({ALIGN_W{1'b1}} << d);
      out_mant_o   = (!out_valid_o || zero_sel || big) ? '0 : neg ? ext : ext >> d;
      out_sticky_o = out_valid_o && !zero_sel && !neg && (big ? |mant_sel : |(ext & mask));
      out_sign_o   = out_valid_o && sign_q[idx_q];
      out_idx_o    = idx_q;
      out_last_o   = out_valid_o && last;
      err_o        = err_q;
   end

   // FSM: capture a vector on accept, walk the index on each beat, flag negative shifts
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         exp_q     <= '0;
         mant_q    <= '0;
         sign_q    <= '0;
         zero_q    <= '0;
         exp_max_q <= '0;
         err_q     <= 1'b0;
      end else begin
         if (xfer && !zero_sel && neg) err_q <= 1'b1;
         if (accept) begin
            exp_q     <= exp_i;
            mant_q    <= mant_i;
            sign_q    <= sign_i;
            zero_q    <= zero_i;
            exp_max_q <= exp_max_i;
            idx_q     <= '0;
            state_q   <= SEND;
         end else if (xfer) begin
            state_q <= last ? IDLE : SEND;
            idx_q   <= last ? '0 : idx_q + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_pdpu_align_serializer.sv
// tb_pdpu_align_serializer: directed and randomized checks of the align serializer against an arithmetic lane model
module tb_pdpu_align_serializer;
   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
   logic signed [8:0] exp_max = '0;
   logic [35:0] exp_v = '0;
   logic [31:0] mant_v = '0;
   logic [3:0]  sign_v = '0, zero_v = '0;
   logic        in_ready, out_valid, out_sticky, out_sign, out_last, err;
   logic [15:0] out_mant;
   logic [1:0]  out_idx;
   int tests = 0, fails = 0;
   typedef struct {int mant; bit st; bit sign; int idx; bit last; bit neg;} beat_t;
   beat_t q[$];
   beat_t b;
   bit err_m;
   int v_em;
   int v_e[4];
   int v_m[4];
   logic [3:0] v_s, v_z;
   wire [21:0] got = {out_valid, out_idx, out_mant, out_sticky, out_sign, out_last};

   pdpu_align_serializer dut (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .exp_max_i(exp_max), .exp_i(exp_v), .mant_i(mant_v), .sign_i(sign_v), .zero_i(zero_v),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_mant_o(out_mant),
      .out_sticky_o(out_sticky), .out_sign_o(out_sign), .out_idx_o(out_idx),
      .out_last_o(out_last), .err_o(err));

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [21:0] exp_vec(input beat_t x);
      return {1'b1, 2'(x.idx), 16'(x.mant), x.st, x.sign, x.last};
   endfunction

   task automatic drive_vec();
      exp_max = 9'(v_em);
      for (int i = 0; i < 4; i++) begin
         exp_v[i*9 +: 9]  = 9'(v_e[i]);
         mant_v[i*8 +: 8] = 8'(v_m[i]);
      end
      sign_v = v_s;
      zero_v = v_z;
   endtask

   task automatic scramble();
      exp_max = 9'($urandom);
      exp_v   = {4'($urandom), $urandom};
      mant_v  = $urandom;
      sign_v  = 4'($urandom);
      zero_v  = 4'($urandom);
   endtask

   task automatic gen_vec(input bit neg_ok);
      v_em = int'($urandom_range(0, 200)) - 100;
      for (int i = 0; i < 4; i++) begin
         v_e[i] = v_em - int'($urandom_range(0, 20));
         if (neg_ok && $urandom_range(0, 7) == 0) v_e[i] = v_em + int'($urandom_range(1, 3));
         v_m[i] = int'($urandom_range(0, 255));
         v_z[i] = $urandom_range(0, 5) == 0;
      end
      v_s = 4'($urandom);
   endtask

   // reference model: align each lane with integer arithmetic on the real shift distance
   task automatic push_vec();
      beat_t x;
      int d, ext;
      for (int i = 0; i < 4; i++) begin
         d = v_em - v_e[i];
         ext = v_m[i] * 256;
         x.idx = i; x.last = (i == 3); x.sign = v_s[i]; x.neg = 0;
         if (v_z[i]) begin x.mant = 0; x.st = 0; end
         else if (d < 0) begin x.mant = ext; x.st = 0; x.neg = 1; end
         else if (d >= 16) begin x.mant = 0; x.st = (v_m[i] != 0); end
         else begin x.mant = ext / (1 << d); x.st = (ext % (1 << d)) != 0; end
         q.push_back(x);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      tests++;
      if (got !== 22'd0) begin fails++; $display("FAIL reset_outputs: got %h expected 000000", got); end
      tests++;
      if ({in_ready, err} !== 2'b10) begin fails++; $display("FAIL reset_ready_err: got %b expected 10", {in_ready, err}); end
   endtask

   task automatic test_align();
      logic [15:0] want [4] = '{16'h8000, 16'h3000, 16'h0020, 16'h0000};
      logic        want_st [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      v_em = 5; v_e = '{5, 3, -5, -20}; v_m = '{8'h80, 8'hC0, 8'h81, 8'hFF}; v_s = 4'b1010; v_z = 4'b0000;
      @(negedge clk); drive_vec(); in_valid = 1'b1; out_ready = 1'b1; #1;
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL align_in_ready: got %b expected 1", in_ready); end
      push_vec();
      @(negedge clk); in_valid = 1'b0; scramble(); #1;
      for (int i = 0; i < 4; i++) begin
         b = q.pop_front();
         tests++;
         if (got !== exp_vec(b)) begin fails++; $display("FAIL align_beat%0d: got %h expected %h", i, got, exp_vec(b)); end
         tests++;
         if ({out_mant, out_sticky} !== {want[i], want_st[i]}) begin fails++; $display("FAIL align_const%0d: got %h/%b expected %h/%b", i, out_mant, out_sticky, want[i], want_st[i]); end
         @(negedge clk); #1;
      end
      tests++;
      if ({out_valid, err} !== 2'b00) begin fails++; $display("FAIL align_done: got valid/err %b expected 00", {out_valid, err}); end
   endtask

   task automatic test_backpressure();
      @(negedge clk); drive_vec(); in_valid = 1'b1; out_ready = 1'b1; #1;
      push_vec();
      @(negedge clk); in_valid = 1'b0; scramble(); #1;
      b = q.pop_front();
      tests++;
      if (got !== exp_vec(b)) begin fails++; $display("FAIL bp_beat0: got %h expected %h", got, exp_vec(b)); end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); out_ready = 1'b0; scramble(); #1;
         tests++;
         if ({got, in_ready} !== {exp_vec(q[0]), 1'b0}) begin fails++; $display("FAIL bp_stall%0d: got %h/%b expected %h/0", k, got, in_ready, exp_vec(q[0])); end
         tests++;
         if (out_mant !== 16'h3000) begin fails++; $display("FAIL bp_hold_mant%0d: got %h expected 3000", k, out_mant); end
      end
      @(negedge clk); out_ready = 1'b1; #1;
      for (int i = 1; i < 4; i++) begin
         b = q.pop_front();
         tests++;
         if (got !== exp_vec(b)) begin fails++; $display("FAIL bp_beat%0d: got %h expected %h", i, got, exp_vec(b)); end
         @(negedge clk); #1;
      end
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_done: got valid %b expected 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      gen_vec(0);
      @(negedge clk); drive_vec(); in_valid = 1'b1; out_ready = 1'b1; #1;
      push_vec();
      @(negedge clk); in_valid = 1'b0; scramble(); #1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            @(negedge clk);
            if (i == 3) begin gen_vec(0); drive_vec(); in_valid = 1'b1; end
            #1;
         end
         b = q.pop_front();
         tests++;
         if (got !== exp_vec(b)) begin fails++; $display("FAIL b2b_a_beat%0d: got %h expected %h", i, got, exp_vec(b)); end
      end
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready: got %b expected 1", in_ready); end
      push_vec();
      @(negedge clk); in_valid = 1'b0; scramble(); #1;
      for (int i = 0; i < 4; i++) begin
         b = q.pop_front();
         tests++;
         if (got !== exp_vec(b)) begin fails++; $display("FAIL b2b_b_beat%0d: got %h expected %h", i, got, exp_vec(b)); end
         @(negedge clk); #1;
      end
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_done: got valid %b expected 0", out_valid); end
   endtask

   task automatic test_zero_neg();
      v_em = 5; v_e = '{5, 3, 7, -5}; v_s = 4'b0110; v_z = 4'b0010;
      for (int i = 0; i < 4; i++) v_m[i] = int'($urandom_range(128, 255));
      @(negedge clk); drive_vec(); in_valid = 1'b1; out_ready = 1'b1; #1;
      push_vec();
      @(negedge clk); in_valid = 1'b0; scramble(); #1;
      for (int i = 0; i < 4; i++) begin
         b = q.pop_front();
         tests++;
         if (got !== exp_vec(b)) begin fails++; $display("FAIL zn_beat%0d: got %h expected %h", i, got, exp_vec(b)); end
         if (i == 1) begin
            tests++;
            if ({out_mant, out_sticky, out_sign} !== {16'h0000, 1'b0, 1'b1}) begin fails++; $display("FAIL zn_zero_lane: got %h/%b/%b expected 0000/0/1", out_mant, out_sticky, out_sign); end
         end
         if (i == 2) begin
            tests++;
            if ({out_mant, err} !== {16'(v_m[2] * 256), 1'b0}) begin fails++; $display("FAIL zn_neg_lane: got %h/err%b expected %h/err0", out_mant, err, 16'(v_m[2] * 256)); end
         end
         if (i == 3) begin
            tests++;
            if (err !== 1'b1) begin fails++; $display("FAIL zn_err_rise: got %b expected 1", err); end
         end
         @(negedge clk); #1;
      end
      tests++;
      if ({out_valid, err} !== 2'b01) begin fails++; $display("FAIL zn_err_sticky: got valid/err %b expected 01", {out_valid, err}); end
   endtask

   task automatic test_reset_mid();
      gen_vec(0);
      @(negedge clk); drive_vec(); in_valid = 1'b1; out_ready = 1'b1; #1;
      push_vec();
      @(negedge clk); in_valid = 1'b0; scramble(); #1;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) begin
            @(negedge clk);
            if (i == 2) rst = 1'b1;
            #1;
         end
         b = q.pop_front();
         tests++;
         if (got !== exp_vec(b)) begin fails++; $display("FAIL rm_beat%0d: got %h expected %h", i, got, exp_vec(b)); end
      end
      q.delete();
      @(negedge clk); rst = 1'b0; #1;
      tests++;
      if ({out_valid, err, in_ready, out_mant} !== {3'b001, 16'h0}) begin fails++; $display("FAIL rm_after_reset: got %b/%b/%b/%h expected 0/0/1/0000", out_valid, err, in_ready, out_mant); end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); #1;
         tests++;
         if (out_valid !== 1'b0) begin fails++; $display("FAIL rm_no_beats%0d: got valid %b expected 0", k, out_valid); end
      end
   endtask

   task automatic test_boundary();
      v_em = 15; v_e = '{0, -1, 15, -100}; v_m = '{8'h80, 8'h80, 8'hC3, 8'hFF}; v_s = 4'b0101; v_z = 4'b0000;
      @(negedge clk); drive_vec(); in_valid = 1'b1; out_ready = 1'b1; #1;
      push_vec();
      @(negedge clk); in_valid = 1'b0; scramble(); #1;
      for (int i = 0; i < 4; i++) begin
         b = q.pop_front();
         tests++;
         if (got !== exp_vec(b)) begin fails++; $display("FAIL bnd_beat%0d: got %h expected %h", i, got, exp_vec(b)); end
         if (i == 0) begin
            tests++;
            if ({out_mant, out_sticky} !== {16'h0001, 1'b0}) begin fails++; $display("FAIL bnd_d15: got %h/%b expected 0001/0", out_mant, out_sticky); end
         end
         if (i == 1) begin
            tests++;
            if ({out_mant, out_sticky} !== {16'h0000, 1'b1}) begin fails++; $display("FAIL bnd_d16: got %h/%b expected 0000/1", out_mant, out_sticky); end
         end
         @(negedge clk); #1;
      end
   endtask

   task automatic test_random();
      int sent = 0;
      bit pend = 0, acc = 0;
      err_m = 0;
      for (int c = 0; c < 3000 && (sent < 30 || q.size() > 0 || pend); c++) begin
         @(negedge clk);
         if (acc) begin in_valid = 1'b0; scramble(); pend = 0; acc = 0; end
         if (!pend && sent < 30 && $urandom_range(0, 3) != 0) begin gen_vec(1); drive_vec(); in_valid = 1'b1; pend = 1; end
         out_ready = $urandom_range(0, 3) != 0;
         #1;
         tests++;
         if (err !== err_m) begin fails++; $display("FAIL rnd_err cycle %0d: got %b expected %b", c, err, err_m); end
         if (out_valid && out_ready) begin
            tests++;
            if (q.size() == 0) begin fails++; $display("FAIL rnd_unexpected_beat: got %h expected none", got); end
            else begin
               b = q.pop_front();
               if (got !== exp_vec(b)) begin fails++; $display("FAIL rnd_beat cycle %0d: got %h expected %h", c, got, exp_vec(b)); end
               if (b.neg) err_m = 1;
            end
         end
         if (in_valid && in_ready) begin push_vec(); sent++; acc = 1; end
      end
      tests++;
      if (sent != 30 || q.size() != 0) begin fails++; $display("FAIL rnd_timeout: got sent %0d pending %0d expected 30/0", sent, q.size()); end
   endtask

   initial begin
      test_reset();
      test_align();
      test_backpressure();
      test_back_to_back();
      test_zero_neg();
      test_reset_mid();
      test_boundary();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
